id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Parametrised ID/EX pipeline register for the pipelined RV32 core; successor to the fixed-width decode-stage output register.
- Adds a valid bit, hold on downstream stall, and an integrated load-use hazard detector that stalls F/D and inserts a bubble into E.
- Flush (branch redirect) clears control with a selectable data-clear mode.
- Sits between decode logic (control unit, register file, immediate extender) and the execute stage.

Parameters:
- XLEN, 32, data/PC width.
- RA_W, 5, register-address width.
- ALUC_W, 4, ALU control width.
- CLEAR_DATA_ON_FLUSH, 0, 1 = flush/bubble also zeroes data fields; 0 = data fields hold their value.
- CNT_W, 16, performance-counter width (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- valid_d  in  1  decode slot holds a real instruction.
- reg_write_d, alu_src_d, mem_write_d, mem_read_d, result_src_d, branch_d  in  1 each  decoded control.
- alu_control_d  in  ALUC_W  decoded ALU op.
- rd1_d, rd2_d, imm_ext_d, pc_d, pcplus4_d  in  XLEN each  decode data.
- rd_d, rs1_d, rs2_d  in  RA_W each  register addresses.
- flush  in  1  squash the instruction entering E.
- stall_e  in  1  execute stage cannot accept; hold E.
- valid_e plus the *_e counterparts of every *_d input above  out  same widths  registered E-stage copies.
- stall_fd  out  1  hold PC and IF/ID register.
- hazard  out  1  load-use hazard detected this cycle.

Behaviour:
- Reset (rst=0, asynchronous): every *_e output and valid_e are 0; counters are 0. Outputs are registered, so latency is 1 cycle from a *_d input to the matching *_e output.
- Hazard (combinational): hazard = valid_e & mem_read_e & (rd_e != 0) & valid_d & ((rd_e == rs1_d) | (rd_e == rs2_d)).
- stall_fd (combinational) = ~flush & (hazard | stall_e).
- Per-edge action, evaluated in priority order:
  1. flush=1 -> squash: valid_e and all control outputs go to 0. Data fields go to 0 if CLEAR_DATA_ON_FLUSH=1, otherwise hold.
  2. stall_e=1 -> hold: all outputs keep their value.
  3. hazard=1 -> bubble: same clearing as squash. D is held upstream by stall_fd, so the instruction re-presents next cycle.
  4. Otherwise -> load: every *_e takes its *_d. A valid_d=0 input loads control as 0, so non-valid slots never write.
- Simultaneous events:
  - flush with stall_e or hazard: flush wins and stall_fd=0.
  - stall_e with hazard: hold; hazard is re-evaluated next cycle.
- rs = x0 never causes a hazard, because rd_e=0 is excluded.
- Back-to-back loads: each dependent consumer costs exactly one bubble.
- Reset asserted mid-stall or mid-bubble: all state clears immediately, and stall_fd drops to 0 because valid_e=0.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs bubble_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0].
  - bubble_cnt increments on each edge taking the bubble action.
  - flush_cnt increments on each edge with flush=1 and valid_e-to-be-overwritten=1 (that is, valid_e or valid_d set).
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then plain load: valid_d=1, rd1_d=32'h1234_5678, rd_d=5 -> one cycle later rd1_e=32'h1234_5678, rd_e=5, valid_e=1; during reset all outputs read 0.
- Load-use: E holds lw with rd_e=7 and mem_read_e=1; D has rs2_d=7 -> hazard=1 and stall_fd=1. Next edge: valid_e=0, reg_write_e=0. Following edge: the dependent instruction loads and hazard=0.
- x0 exemption: lw with rd_e=0, D rs1_d=0 -> hazard=0 and normal load.
- Flush priority: flush=1 together with stall_e=1 and hazard=1 -> stall_fd=0; next edge valid_e=0 and mem_write_e=0; with CLEAR_DATA_ON_FLUSH=0 pc_e keeps its old value, with 1 pc_e=0.
- Stall hold: stall_e=1 for 3 cycles while *_d changes -> all *_e are unchanged and stall_fd=1 throughout.
- ID_EX_PERF_CNT_EN with CNT_W=2: 5 hazard bubbles -> bubble_cnt=3 (saturated); 2 valid flushes -> flush_cnt=2; then rst=0 -> both counters 0.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid bit, downstream-stall hold, flush and load-use bubble insertion.
// Define ID_EX_PERF_CNT_EN to add saturating bubble/flush performance counters.
module id_ex_stage_reg #(
   parameter int XLEN                = 32,
   parameter int RA_W                = 5,
   parameter int ALUC_W              = 4,
   parameter bit CLEAR_DATA_ON_FLUSH = 1'b0,
   parameter int CNT_W               = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_d,
   input  logic              reg_write_d,
   input  logic              alu_src_d,
   input  logic              mem_write_d,
   input  logic              mem_read_d,
   input  logic              result_src_d,
   input  logic              branch_d,
   input  logic [ALUC_W-1:0] alu_control_d,
   input  logic [XLEN-1:0]   rd1_d,
   input  logic [XLEN-1:0]   rd2_d,
   input  logic [XLEN-1:0]   imm_ext_d,
   input  logic [XLEN-1:0]   pc_d,
   input  logic [XLEN-1:0]   pcplus4_d,
   input  logic [RA_W-1:0]   rd_d,
   input  logic [RA_W-1:0]   rs1_d,
   input  logic [RA_W-1:0]   rs2_d,
   input  logic              flush,
   input  logic              stall_e,
   output logic              valid_e,
   output logic              reg_write_e,
   output logic              alu_src_e,
   output logic              mem_write_e,
   output logic              mem_read_e,
   output logic              result_src_e,
   output logic              branch_e,
   output logic [ALUC_W-1:0] alu_control_e,
   output logic [XLEN-1:0]   rd1_e,
   output logic [XLEN-1:0]   rd2_e,
   output logic [XLEN-1:0]   imm_ext_e,
   output logic [XLEN-1:0]   pc_e,
   output logic [XLEN-1:0]   pcplus4_e,
   output logic [RA_W-1:0]   rd_e,
   output logic [RA_W-1:0]   rs1_e,
   output logic [RA_W-1:0]   rs2_e,
   output logic              stall_fd,
   output logic              hazard
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              alu_src;
      logic              mem_write;
      logic              mem_read;
      logic              result_src;
      logic              branch;
      logic [ALUC_W-1:0] alu_control;
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   imm_ext;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   pcplus4;
      logic [RA_W-1:0]   rd;
      logic [RA_W-1:0]   rs1;
      logic [RA_W-1:0]   rs2;
   } ex_stage_t;

   ex_stage_t stage_q, stage_d;
   ex_stage_t load_v, squash_v;
   logic      do_bubble;

   always_comb begin
      hazard = stage_q.valid & stage_q.mem_read & (stage_q.rd != '0) & valid_d &
               ((stage_q.rd == rs1_d) | (stage_q.rd == rs2_d));
      stall_fd  = ~flush & (hazard | stall_e);
      do_bubble = ~flush & ~stall_e & hazard;

      // Non-valid slots load with control forced low so they can never write.
      load_v.valid       = valid_d;
      load_v.reg_write   = valid_d & reg_write_d;
      load_v.alu_src     = valid_d & alu_src_d;
      load_v.mem_write   = valid_d & mem_write_d;
      load_v.mem_read    = valid_d & mem_read_d;
      load_v.result_src  = valid_d & result_src_d;
      load_v.branch      = valid_d & branch_d;
      load_v.alu_control = valid_d ? alu_control_d : '0;
      load_v.rd1         = rd1_d;
      load_v.rd2         = rd2_d;
      load_v.imm_ext     = imm_ext_d;
      load_v.pc          = pc_d;
      load_v.pcplus4     = pcplus4_d;
      load_v.rd          = rd_d;
      load_v.rs1         = rs1_d;
      load_v.rs2         = rs2_d;

      squash_v             = stage_q;
      squash_v.valid       = 1'b0;
      squash_v.reg_write   = 1'b0;
      squash_v.alu_src     = 1'b0;
      squash_v.mem_write   = 1'b0;
      squash_v.mem_read    = 1'b0;
      squash_v.result_src  = 1'b0;
      squash_v.branch      = 1'b0;
      squash_v.alu_control = '0;
      if (CLEAR_DATA_ON_FLUSH) begin
         squash_v.rd1     = '0;
         squash_v.rd2     = '0;
         squash_v.imm_ext = '0;
         squash_v.pc      = '0;
         squash_v.pcplus4 = '0;
         squash_v.rd      = '0;
         squash_v.rs1     = '0;
         squash_v.rs2     = '0;
      end

      // Priority: flush, then downstream stall, then load-use bubble, then load.
      stage_d = stage_q;
      if (flush) begin
         stage_d = squash_v;
      end else if (stall_e) begin
         stage_d = stage_q;
      end else if (hazard) begin
         stage_d = squash_v;
      end else begin
         stage_d = load_v;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign valid_e       = stage_q.valid;
   assign reg_write_e   = stage_q.reg_write;
   assign alu_src_e     = stage_q.alu_src;
   assign mem_write_e   = stage_q.mem_write;
   assign mem_read_e    = stage_q.mem_read;
   assign result_src_e  = stage_q.result_src;
   assign branch_e      = stage_q.branch;
   assign alu_control_e = stage_q.alu_control;
   assign rd1_e         = stage_q.rd1;
   assign rd2_e         = stage_q.rd2;
   assign imm_ext_e     = stage_q.imm_ext;
   assign pc_e          = stage_q.pc;
   assign pcplus4_e     = stage_q.pcplus4;
   assign rd_e          = stage_q.rd;
   assign rs1_e         = stage_q.rs1;
   assign rs2_e         = stage_q.rs2;

`ifdef ID_EX_PERF_CNT_EN
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      if (do_bubble && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
      // Only flushes that actually discard a real instruction are counted.
      if (flush && (stage_q.valid || valid_d) && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
   assign flush_cnt  = flush_cnt_q;
`else
   logic unused_perf;
   assign unused_perf = do_bubble ^ (CNT_W[0]);
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: two instances differing only in flush data-clear mode.
`timescale 1ns/1ps
module tb_id_ex_stage_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_d, reg_write_d, alu_src_d, mem_write_d, mem_read_d, result_src_d, branch_d;
   logic [3:0]  alu_control_d;
   logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d, pcplus4_d;
   logic [4:0]  rd_d, rs1_d, rs2_d;
   logic        flush, stall_e;

   logic        valid_e, reg_write_e, alu_src_e, mem_write_e, mem_read_e, result_src_e, branch_e;
   logic [3:0]  alu_control_e;
   logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e;
   logic [4:0]  rd_e, rs1_e, rs2_e;
   logic        stall_fd, hazard;

   logic        valid_c, reg_write_c, alu_src_c, mem_write_c, mem_read_c, result_src_c, branch_c;
   logic [3:0]  alu_control_c;
   logic [31:0] rd1_c, rd2_c, imm_ext_c, pc_c, pcplus4_c;
   logic [4:0]  rd_c, rs1_c, rs2_c;
   logic        stall_fd_c, hazard_c;
`ifdef ID_EX_PERF_CNT_EN
   logic [1:0]  bubble_cnt, flush_cnt, bubble_cnt_c, flush_cnt_c;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_ex_stage_reg #(.CLEAR_DATA_ON_FLUSH(1'b0), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .valid_d(valid_d), .reg_write_d(reg_write_d), .alu_src_d(alu_src_d),
      .mem_write_d(mem_write_d), .mem_read_d(mem_read_d), .result_src_d(result_src_d),
      .branch_d(branch_d), .alu_control_d(alu_control_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
      .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .rd_d(rd_d), .rs1_d(rs1_d),
      .rs2_d(rs2_d), .flush(flush), .stall_e(stall_e), .valid_e(valid_e),
      .reg_write_e(reg_write_e), .alu_src_e(alu_src_e), .mem_write_e(mem_write_e),
      .mem_read_e(mem_read_e), .result_src_e(result_src_e), .branch_e(branch_e),
      .alu_control_e(alu_control_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
      .pc_e(pc_e), .pcplus4_e(pcplus4_e), .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .stall_fd(stall_fd), .hazard(hazard)
`ifdef ID_EX_PERF_CNT_EN
      , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
   );

   id_ex_stage_reg #(.CLEAR_DATA_ON_FLUSH(1'b1), .CNT_W(2)) dut_clr (
      .clk(clk), .rst(rst), .valid_d(valid_d), .reg_write_d(reg_write_d), .alu_src_d(alu_src_d),
      .mem_write_d(mem_write_d), .mem_read_d(mem_read_d), .result_src_d(result_src_d),
      .branch_d(branch_d), .alu_control_d(alu_control_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
      .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .rd_d(rd_d), .rs1_d(rs1_d),
      .rs2_d(rs2_d), .flush(flush), .stall_e(stall_e), .valid_e(valid_c),
      .reg_write_e(reg_write_c), .alu_src_e(alu_src_c), .mem_write_e(mem_write_c),
      .mem_read_e(mem_read_c), .result_src_e(result_src_c), .branch_e(branch_c),
      .alu_control_e(alu_control_c), .rd1_e(rd1_c), .rd2_e(rd2_c), .imm_ext_e(imm_ext_c),
      .pc_e(pc_c), .pcplus4_e(pcplus4_c), .rd_e(rd_c), .rs1_e(rs1_c), .rs2_e(rs2_c),
      .stall_fd(stall_fd_c), .hazard(hazard_c)
`ifdef ID_EX_PERF_CNT_EN
      , .bubble_cnt(bubble_cnt_c), .flush_cnt(flush_cnt_c)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_d();
      valid_d = 0; reg_write_d = 0; alu_src_d = 0; mem_write_d = 0; mem_read_d = 0;
      result_src_d = 0; branch_d = 0; alu_control_d = 0; rd1_d = 0; rd2_d = 0;
      imm_ext_d = 0; pc_d = 0; pcplus4_d = 0; rd_d = 0; rs1_d = 0; rs2_d = 0;
   endtask

   // One rising edge, then settle at the following falling edge for sampling.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      clear_d();
      flush = 0; stall_e = 0; rst = 0;
      valid_d = 1; reg_write_d = 1; mem_read_d = 1; rd1_d = 32'hDEAD_BEEF; rd_d = 5'd3; pc_d = 32'h44;
      step(); step();
      chk("rst_valid_e", 32'(valid_e), 32'd0);
      chk("rst_reg_write_e", 32'(reg_write_e), 32'd0);
      chk("rst_rd1_e", rd1_e, 32'd0);
      chk("rst_rd_e", 32'(rd_e), 32'd0);
      chk("rst_pc_e", pc_e, 32'd0);
      chk("rst_stall_fd", 32'(stall_fd), 32'd0);
      $display("reset: valid_e=%0d rd1_e=%h", valid_e, rd1_e);

      rst = 1;
      clear_d();
      valid_d = 1; reg_write_d = 1; rd1_d = 32'h1234_5678; rd_d = 5'd5; pc_d = 32'h100;
      step();
      chk("load_rd1_e", rd1_e, 32'h1234_5678);
      chk("load_rd_e", 32'(rd_e), 32'd5);
      chk("load_valid_e", 32'(valid_e), 32'd1);
      chk("load_reg_write_e", 32'(reg_write_e), 32'd1);
      chk("load_pc_e", pc_e, 32'h100);
      $display("load: rd1_e=%h rd_e=%0d valid_e=%0d", rd1_e, rd_e, valid_e);

      // Load-use: lw x7 in E, consumer reads x7 through rs2.
      clear_d();
      valid_d = 1; mem_read_d = 1; reg_write_d = 1; rd_d = 5'd7; pc_d = 32'h200; rs1_d = 5'd1; rs2_d = 5'd2;
      step();
      clear_d();
      valid_d = 1; reg_write_d = 1; rs1_d = 5'd3; rs2_d = 5'd7; rd_d = 5'd8; pc_d = 32'h204;
      #1;
      chk("lu_hazard", 32'(hazard), 32'd1);
      chk("lu_stall_fd", 32'(stall_fd), 32'd1);
      step();
      chk("lu_bubble_valid_e", 32'(valid_e), 32'd0);
      chk("lu_bubble_reg_write_e", 32'(reg_write_e), 32'd0);
      chk("lu_bubble_mem_read_e", 32'(mem_read_e), 32'd0);
      chk("lu_bubble_pc_hold", pc_e, 32'h200);
      chk("lu_bubble_pc_clr", pc_c, 32'd0);
      step();
      chk("lu_dep_valid_e", 32'(valid_e), 32'd1);
      chk("lu_dep_pc_e", pc_e, 32'h204);
      chk("lu_dep_rd_e", 32'(rd_e), 32'd8);
      chk("lu_dep_hazard", 32'(hazard), 32'd0);
      $display("load-use: bubble inserted, dependent pc_e=%h", pc_e);

      // x0 destination never stalls.
      clear_d();
      valid_d = 1; mem_read_d = 1; rd_d = 5'd0; pc_d = 32'h300;
      step();
      clear_d();
      valid_d = 1; rs1_d = 5'd0; rs2_d = 5'd0; rd_d = 5'd9; pc_d = 32'h304;
      #1;
      chk("x0_hazard", 32'(hazard), 32'd0);
      chk("x0_stall_fd", 32'(stall_fd), 32'd0);
      step();
      chk("x0_pc_e", pc_e, 32'h304);
      chk("x0_valid_e", 32'(valid_e), 32'd1);
      $display("x0: hazard=%0d pc_e=%h", hazard, pc_e);

      // Flush beats simultaneous stall and hazard.
      clear_d();
      valid_d = 1; mem_read_d = 1; mem_write_d = 1; rd_d = 5'd7; pc_d = 32'h400;
      step();
      chk("fl_pre_mem_write_e", 32'(mem_write_e), 32'd1);
      clear_d();
      valid_d = 1; rs1_d = 5'd7; pc_d = 32'h404; stall_e = 1; flush = 1;
      #1;
      chk("fl_hazard", 32'(hazard), 32'd1);
      chk("fl_stall_fd", 32'(stall_fd), 32'd0);
      step();
      chk("fl_valid_e", 32'(valid_e), 32'd0);
      chk("fl_mem_write_e", 32'(mem_write_e), 32'd0);
      chk("fl_pc_hold", pc_e, 32'h400);
      chk("fl_pc_clr", pc_c, 32'd0);
      chk("fl_valid_clr", 32'(valid_c), 32'd0);
      flush = 0; stall_e = 0;
      $display("flush: valid_e=%0d pc_e=%h pc_e(clear)=%h", valid_e, pc_e, pc_c);

      // Downstream stall holds for three cycles while D changes.
      clear_d();
      valid_d = 1; reg_write_d = 1; rd1_d = 32'h0000_AAAA; rd_d = 5'd10; pc_d = 32'h500;
      step();
      for (int i = 0; i < 3; i++) begin
         stall_e = 1;
         valid_d = (i != 1); reg_write_d = 0; rd1_d = 32'(i + 1); rd_d = 5'(i + 20); pc_d = 32'h600 + 32'(i);
         #1;
         chk("st_stall_fd", 32'(stall_fd), 32'd1);
         step();
         chk("st_pc_e", pc_e, 32'h500);
         chk("st_rd1_e", rd1_e, 32'h0000_AAAA);
         chk("st_valid_e", 32'(valid_e), 32'd1);
         chk("st_reg_write_e", 32'(reg_write_e), 32'd1);
         chk("st_rd_e", 32'(rd_e), 32'd10);
         $display("stall cycle %0d: pc_e=%h stall_fd=%0d", i, pc_e, stall_fd);
      end
      stall_e = 0;

      // Non-valid slot: data loads, control forced low.
      clear_d();
      valid_d = 0; reg_write_d = 1; mem_write_d = 1; branch_d = 1; pc_d = 32'h700;
      step();
      chk("nv_valid_e", 32'(valid_e), 32'd0);
      chk("nv_reg_write_e", 32'(reg_write_e), 32'd0);
      chk("nv_mem_write_e", 32'(mem_write_e), 32'd0);
      chk("nv_branch_e", 32'(branch_e), 32'd0);
      chk("nv_pc_e", pc_e, 32'h700);
      $display("non-valid: valid_e=%0d pc_e=%h", valid_e, pc_e);

      // Reset asserted while a load-use stall is pending.
      clear_d();
      valid_d = 1; mem_read_d = 1; rd_d = 5'd7; pc_d = 32'h800;
      step();
      clear_d();
      valid_d = 1; rs1_d = 5'd7;
      #1;
      chk("mr_pre_stall_fd", 32'(stall_fd), 32'd1);
      rst = 0;
      #1;
      chk("mr_valid_e", 32'(valid_e), 32'd0);
      chk("mr_stall_fd", 32'(stall_fd), 32'd0);
      chk("mr_pc_e", pc_e, 32'd0);
      @(negedge clk);
      rst = 1;
      $display("mid-stall reset: valid_e=%0d stall_fd=%0d", valid_e, stall_fd);

`ifdef ID_EX_PERF_CNT_EN
      for (int i = 0; i < 5; i++) begin
         clear_d();
         valid_d = 1; mem_read_d = 1; rd_d = 5'd7;
         step();
         clear_d();
         valid_d = 1; rs1_d = 5'd7; rd_d = 5'd8;
         step();
         step();
      end
      chk("pc_bubble_cnt_sat", 32'(bubble_cnt), 32'd3);
      chk("pc_flush_cnt_zero", 32'(flush_cnt), 32'd0);
      clear_d();
      valid_d = 1; flush = 1;
      step();
      step();
      flush = 0;
      chk("pc_flush_cnt", 32'(flush_cnt), 32'd2);
      rst = 0;
      #1;
      chk("pc_bubble_cnt_rst", 32'(bubble_cnt), 32'd0);
      chk("pc_flush_cnt_rst", 32'(flush_cnt), 32'd0);
      @(negedge clk);
      rst = 1;
      $display("perf: counters checked and reset");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
